// File: rtl/instr_fetch.sv
// Instruction fetch unit for the LEGv8 datapath: owns the PC, fetches one
// instruction word per req/ack handshake and presents it to decode.
module instr_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        halt,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [63:0] pc,
    output logic [63:0] link_addr,
    input  logic        BrTaken,
    input  logic        UncondBr,
    input  logic        BR,
    input  logic [63:0] br_target
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [63:0] br_offset;
    logic [63:0] next_pc;

    // Word offsets scaled to bytes: imm26 for B/BL, imm19 for CBZ/B.cond.
    always_comb begin
        br_offset = '0;
        if (UncondBr) begin
            br_offset = {{36{instr_q[25]}}, instr_q[25:0], 2'b00};
        end else begin
            br_offset = {{43{instr_q[23]}}, instr_q[23:5], 2'b00};
        end
    end

    // if/else chain so an unknown BR/BrTaken falls through to pc + 4.
    always_comb begin
        next_pc = pc_q + 64'd4;
        if (BR) begin
            next_pc = {br_target[63:2], 2'b00};
        end else if (BrTaken) begin
            next_pc = pc_q + br_offset;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        unique case (state_q)
            IDLE: begin
                if (!halt) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    pc_d    = next_pc;
                    state_d = halt ? IDLE : REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign imem_req    = (state_q == REQ);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == HOLD);
    assign pc          = pc_q;
    assign link_addr   = pc_q + 64'd4;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with hand-computed PC targets.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        halt;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [63:0] pc;
    logic [63:0] link_addr;
    logic        BrTaken;
    logic        UncondBr;
    logic        BR;
    logic [63:0] br_target;

    int unsigned n_vec = 0;
    int unsigned n_mis = 0;
    logic [31:0] cur_word;
    logic [63:0] cur_pc;

    localparam logic [31:0] ADDI    = 32'h9100_0421;
    localparam logic [31:0] B_M4    = 32'h17FF_FFFC;
    localparam logic [31:0] CBZ_P3  = 32'hB400_0060;
    localparam logic [31:0] CBZ_M2  = 32'hB4FF_FFC0;

    instr_fetch #(.RESET_PC(64'h0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .halt        (halt),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc),
        .link_addr   (link_addr),
        .BrTaken     (BrTaken),
        .UncondBr    (UncondBr),
        .BR          (BR),
        .br_target   (br_target)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Entered with the DUT in its first REQ cycle for this fetch.
    task automatic do_fetch(input logic [63:0] addr, input logic [31:0] word,
                            input int unsigned waits);
        check("req", imem_req, 1'b1);
        check("addr", imem_addr, addr);
        for (int unsigned i = 0; i < waits; i++) begin
            tick();
            check("req_wait", imem_req, 1'b1);
            check("addr_wait", imem_addr, addr);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check("valid", instr_valid, 1'b1);
        check("instr", instr, word);
        check("pc_hold", pc, addr);
        check("req_hold", imem_req, 1'b0);
        check("link", link_addr, addr + 64'd4);
        cur_word = word;
        cur_pc   = addr;
    endtask

    // Entered in HOLD; stalls, then accepts with the given branch inputs.
    task automatic do_accept(input int unsigned stall, input logic br, input logic taken,
                             input logic uncond, input logic [63:0] tgt, input logic hlt,
                             input logic [63:0] exp_pc);
        for (int unsigned i = 0; i < stall; i++) begin
            instr_ready = 1'b0;
            BR          = 1'b1;
            BrTaken     = 1'b1;
            br_target   = 64'h5555_0000;
            tick();
            check("stall_valid", instr_valid, 1'b1);
            check("stall_instr", instr, cur_word);
            check("stall_pc", pc, cur_pc);
        end
        instr_ready = 1'b1;
        BR          = br;
        BrTaken     = taken;
        UncondBr    = uncond;
        br_target   = tgt;
        halt        = hlt;
        tick();
        instr_ready = 1'b0;
        BR          = 1'b0;
        BrTaken     = 1'b0;
        UncondBr    = 1'b0;
        br_target   = '0;
        check("next_pc", pc, exp_pc);
        check("next_addr", imem_addr, exp_pc);
        check("next_req", imem_req, !hlt);
        check("next_valid", instr_valid, 1'b0);
        check("next_link", link_addr, exp_pc + 64'd4);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n       = 1'b0;
        halt        = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b0;
        BrTaken     = 1'b0;
        UncondBr    = 1'b0;
        BR          = 1'b0;
        br_target   = '0;
        #2;
        check("rst_pc", pc, 64'h0);
        check("rst_addr", imem_addr, 64'h0);
        check("rst_req", imem_req, 1'b0);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 32'h0);
        check("rst_link", link_addr, 64'h4);
        tick();
        rst_n = 1'b1;
        tick();

        // Sequential zero-wait fetch
        do_fetch(64'h0, ADDI, 0);
        do_accept(0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 64'h4);
        do_fetch(64'h4, ADDI, 0);
        do_accept(0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 64'h8);
        do_fetch(64'h8, ADDI, 0);
        do_accept(0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 64'hC);
        do_fetch(64'hC, ADDI, 0);
        do_accept(0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 64'h10);

        // Wait states and backpressure
        do_fetch(64'h10, ADDI, 3);
        do_accept(4, 1'b0, 1'b0, 1'b0, '0, 1'b0, 64'h14);

        // Register branch to 0x100, then B -4 words
        do_fetch(64'h14, ADDI, 0);
        do_accept(0, 1'b1, 1'b0, 1'b0, 64'h100, 1'b0, 64'h100);
        do_fetch(64'h100, B_M4, 0);
        do_accept(0, 1'b0, 1'b1, 1'b1, '0, 1'b0, 64'hF0);

        // CBZ +3 at 0x40: taken, not taken, unknown
        do_fetch(64'hF0, ADDI, 0);
        do_accept(0, 1'b1, 1'b0, 1'b0, 64'h40, 1'b0, 64'h40);
        do_fetch(64'h40, CBZ_P3, 1);
        do_accept(0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 64'h4C);
        do_fetch(64'h4C, ADDI, 0);
        do_accept(0, 1'b1, 1'b0, 1'b0, 64'h40, 1'b0, 64'h40);
        do_fetch(64'h40, CBZ_P3, 0);
        do_accept(0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 64'h44);
        do_fetch(64'h44, ADDI, 0);
        do_accept(0, 1'b1, 1'b0, 1'b0, 64'h40, 1'b0, 64'h40);
        do_fetch(64'h40, CBZ_P3, 0);
        do_accept(0, 1'b0, 1'bx, 1'b0, '0, 1'b0, 64'h44);

        // CBZ -2 words exercises imm19 sign extension
        do_fetch(64'h44, CBZ_M2, 0);
        do_accept(0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 64'h3C);

        // BR with unaligned target and unknown BrTaken
        do_fetch(64'h3C, ADDI, 0);
        do_accept(0, 1'b1, 1'bx, 1'b0, 64'h2003, 1'b0, 64'h2000);

        // Wrap-around fall-through
        do_fetch(64'h2000, ADDI, 0);
        do_accept(0, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC);
        do_fetch(64'hFFFF_FFFF_FFFF_FFFC, ADDI, 0);
        do_accept(0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 64'h0);

        // Halt at accept; stray ack in IDLE must be ignored
        do_fetch(64'h0, ADDI, 0);
        do_accept(0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 64'h4);
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        tick();
        check("halt_req", imem_req, 1'b0);
        check("halt_valid", instr_valid, 1'b0);
        check("halt_instr", instr, ADDI);
        check("halt_pc", pc, 64'h4);
        imem_ack = 1'b0;
        halt     = 1'b0;
        tick();
        check("resume_req", imem_req, 1'b1);
        check("resume_addr", imem_addr, 64'h4);

        // Async reset mid-REQ with ack during reset
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_pc", pc, 64'h0);
        check("arst_req", imem_req, 1'b0);
        check("arst_valid", instr_valid, 1'b0);
        imem_ack   = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        tick();
        check("arst_ack_valid", instr_valid, 1'b0);
        check("arst_ack_instr", instr, 32'h0);
        rst_n = 1'b1;
        tick();
        check("post_rst_req", imem_req, 1'b1);
        check("post_rst_valid", instr_valid, 1'b0);
        imem_ack = 1'b0;

        // halt raised during REQ: fetch still completes and is presented
        halt = 1'b1;
        do_fetch(64'h0, ADDI, 1);
        do_accept(1, 1'b0, 1'b0, 1'b0, '0, 1'b1, 64'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the 64-bit LEGv8 datapath. It holds the PC, fetches 32-bit instruction words from instruction memory over a req/ack handshake, and presents one instruction at a time to the decode/control stage. It receives that stage's branch decisions (BrTaken, UncondBr, BR) for the presented instruction and computes the next PC from them. It is the producer end of the instruction path whose consumer is the control decoder.

## Interface
Parameters:
- RESET_PC, 64'h0: PC loaded on reset; must be word-aligned.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- halt  in  1  when high, no new fetch is started.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  64  fetch byte address; equals pc.
- imem_ack  in  1  memory response; imem_rdata valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- instr  out  32  instruction presented to decode.
- instr_valid  out  1  instr is valid.
- instr_ready  in  1  decode consumes instr this cycle.
- pc  out  64  address of the current or presented instruction.
- link_addr  out  64  pc + 4, the BL return value.
- BrTaken  in  1  branch taken for the presented instr.
- UncondBr  in  1  1: imm26 offset (B/BL); 0: imm19 offset (CBZ/B.cond).
- BR  in  1  register-indirect branch.
- br_target  in  64  register value for BR (Rd read data).

## Operation
- FSM states: IDLE, REQ, HOLD.
- IDLE: imem_req=0, instr_valid=0. Stays in IDLE while halt=1. Goes to REQ on the next edge when halt=0.
- REQ: imem_req=1, imem_addr=pc. When imem_ack=1: load imem_rdata into instr and go to HOLD. imem_ack outside REQ is ignored.
- HOLD: instr_valid=1; instr and pc are stable. On instr_valid & instr_ready (accept):
  - load the next PC;
  - go to IDLE if halt=1, else to REQ.
- Next PC, evaluated at accept, in priority order:
  - BR=1: br_target with bits [1:0] forced to 0.
  - else BrTaken=1: pc + (sign-extended offset << 2). Offset is instr[25:0] if UncondBr=1, else instr[23:5].
  - else: pc + 4.
- All PC arithmetic is 64-bit and wraps modulo 2^64; no overflow detection.
- Branch inputs are sampled only at accept and ignored at all other times.
- Any branch input that is not a definite 1 (including X from undecoded opcodes) is treated as 0. An unknown opcode therefore falls through to pc + 4.
- link_addr is pc + 4 at all times (combinational from pc).

## Timing
- Reset values: state=IDLE, pc=RESET_PC, imem_addr=RESET_PC, imem_req=0, instr=32'h0, instr_valid=0, link_addr=RESET_PC+4.
- First rising edge after rst_n deasserts with halt=0: enter REQ, so imem_req=1 in the following cycle.
- Request holding: imem_req and imem_addr stay constant from request assertion until the ack cycle inclusive.
- Ack timing: ack may arrive in the first REQ cycle (zero wait states).
- Fetch latency: ack in cycle N gives instr_valid=1 in cycle N+1.
- Accept latency: accept in cycle M gives the new pc and imem_req=1 in cycle M+1.
- Peak throughput: one instruction per 2 cycles.
- Backpressure: instr_ready=0 in HOLD holds instr, pc and instr_valid indefinitely.
- halt asserted in REQ: the outstanding fetch completes and is presented normally. halt is checked only in IDLE and at accept.
- Asynchronous reset mid-fetch (REQ or HOLD): immediately restores reset values. An ack arriving during or after reset for the aborted request is dropped, because the state is IDLE.
- Simultaneous accept and halt: pc updates, state becomes IDLE, no request is issued.

## Test plan
- Reset and sequential fetch:
  - stimulus: RESET_PC=0, zero-wait memory, instr_ready=1, words are ADDI;
  - required: imem_addr sequence 0,4,8,C; instr_valid pulses every 2nd cycle; link_addr = pc+4.
- Wait states and backpressure:
  - stimulus: ack delayed 3 cycles, then instr_ready=0 for 4 cycles;
  - required: imem_addr stable through the wait; instr/pc stable in HOLD; exactly one accept.
- Unconditional branch:
  - stimulus: pc=0x100, instr=0x17FFFFFC (B, imm26=-4), BrTaken=1, UncondBr=1 at accept;
  - required: next imem_addr=0xF0.
- Conditional branch:
  - stimulus: CBZ at pc=0x40 with imm19=3, UncondBr=0;
  - required: BrTaken=1 gives next pc 0x4C; BrTaken=0 gives 0x44; BrTaken=X gives 0x44.
- Register branch and wrap-around:
  - stimulus 1: BR=1, br_target=0x2003, BrTaken=X;
  - required 1: next pc 0x2000.
  - stimulus 2: pc=0xFFFF_FFFF_FFFF_FFFC with fall-through;
  - required 2: next pc 0.
- Halt and reset mid-operation:
  - stimulus 1: halt at accept;
  - required 1: IDLE, imem_req=0; fetch resumes at the updated pc after halt drops.
  - stimulus 2: rst_n low during REQ, with ack asserted during reset;
  - required 2: pc=RESET_PC and instr_valid=0 immediately; the ack is ignored.
